// File: rtl/mem_line_pkg.sv
// rtl/mem_line_pkg.sv - shared types and helpers for the cache line memory engine
// Beat geometry is fixed at 64 bits; line geometry is set per instance.
package mem_line_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_GAP,
      WR_REQ,
      WR_GAP,
      DONE
   } state_t;

   localparam int BEAT_BYTES     = 8;
   localparam int BEAT_BITS      = BEAT_BYTES * 8;
   localparam int DEF_LINE_BYTES = 32;

   typedef logic [DEF_LINE_BYTES*8-1:0] line_t;

   function automatic int beat_count(input int line_bytes);
      return line_bytes / BEAT_BYTES;
   endfunction

endpackage

// File: rtl/mem_line_engine.sv
// rtl/mem_line_engine.sv - line refill/writeback initiator toward physical memory
// Splits one cache line into 64-bit beats, each with an enable/ack handshake and a timeout.
module mem_line_engine
   import mem_line_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int LINE_BYTES  = DEF_LINE_BYTES,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_W-1:0]       req_addr,
   input  logic [LINE_BYTES*8-1:0] req_wdata,
   output logic                    resp_valid,
   output logic [LINE_BYTES*8-1:0] resp_rdata,
   output logic                    resp_err,
   output logic [ADDR_W-1:0]       mem_addr,
   output logic                    mem_rd_en,
   output logic                    mem_wd_en,
   output logic [BEAT_BITS-1:0]    mem_wd_data,
   input  logic [BEAT_BITS-1:0]    mem_data,
   input  logic                    mem_data_valid,
   input  logic                    mem_wd_valid
);

   localparam int BEATS      = beat_count(LINE_BYTES);
   localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1);
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);

   state_t                    state_q;
   logic [BEAT_W-1:0]         beat_q;
   logic [TMO_W-1:0]          tmo_q;
   logic                      err_q;
   logic [ADDR_W-1:0]         base_q;
   logic [LINE_BYTES*8-1:0]   wline_q;
   logic [LINE_BYTES*8-1:0]   line_q;

   logic [BEAT_W-1:0]         beat_d;
   logic [ADDR_W-1:0]         base_d;
   logic                      busy;
   logic                      last_beat;
   logic                      tmo_exp;

   always_comb begin
      beat_d    = beat_q + 1'b1;
      base_d    = req_addr & ~ADDR_W'(LINE_BYTES - 1);
      busy      = state_q inside {RD_REQ, RD_GAP, WR_REQ, WR_GAP};
      last_beat = (beat_q == BEAT_W'(BEATS - 1));
      tmo_exp   = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
   end

   function automatic logic [ADDR_W-1:0] beat_addr(input logic [BEAT_W-1:0] b);
      return base_q + (ADDR_W'(b) << BEAT_SHIFT);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         beat_q      <= '0;
         tmo_q       <= '0;
         err_q       <= 1'b0;
         base_q      <= '0;
         wline_q     <= '0;
         line_q      <= '0;
         req_ready   <= 1'b0;
         resp_valid  <= 1'b0;
         resp_rdata  <= '0;
         resp_err    <= 1'b0;
         mem_addr    <= '0;
         mem_rd_en   <= 1'b0;
         mem_wd_en   <= 1'b0;
         mem_wd_data <= '0;
      end else if (busy && tmo_exp) begin
         // Hung memory: abandon the line and report it as an error completion.
         mem_rd_en  <= 1'b0;
         mem_wd_en  <= 1'b0;
         err_q      <= 1'b1;
         resp_err   <= 1'b1;
         resp_valid <= 1'b1;
         tmo_q      <= '0;
         state_q    <= DONE;
      end else begin
         if (busy) tmo_q <= tmo_q + 1'b1;
         case (state_q)
            IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  base_q    <= base_d;
                  wline_q   <= req_wdata;
                  beat_q    <= '0;
                  err_q     <= 1'b0;
                  tmo_q     <= '0;
                  mem_addr  <= base_d;
                  if (req_write) begin
                     mem_wd_en   <= 1'b1;
                     mem_wd_data <= req_wdata[BEAT_BITS-1:0];
                     state_q     <= WR_REQ;
                  end else begin
                     mem_rd_en <= 1'b1;
                     state_q   <= RD_REQ;
                  end
               end
            end
            RD_REQ: begin
               if (mem_data_valid) begin
                  line_q[beat_q*BEAT_BITS +: BEAT_BITS] <= mem_data;
                  mem_rd_en <= 1'b0;
                  tmo_q     <= '0;
                  state_q   <= RD_GAP;
               end
            end
            RD_GAP: begin
               // Ack lingers while memory still sees the lagging enable; wait it out.
               if (!mem_data_valid) begin
                  tmo_q <= '0;
                  if (last_beat) begin
                     resp_rdata <= line_q;
                     resp_valid <= 1'b1;
                     resp_err   <= err_q;
                     state_q    <= DONE;
                  end else begin
                     beat_q    <= beat_d;
                     mem_addr  <= beat_addr(beat_d);
                     mem_rd_en <= 1'b1;
                     state_q   <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (mem_wd_valid) begin
                  mem_wd_en <= 1'b0;
                  tmo_q     <= '0;
                  state_q   <= WR_GAP;
               end
            end
            WR_GAP: begin
               if (!mem_wd_valid) begin
                  tmo_q <= '0;
                  if (last_beat) begin
                     resp_valid <= 1'b1;
                     resp_err   <= err_q;
                     state_q    <= DONE;
                  end else begin
                     beat_q      <= beat_d;
                     mem_addr    <= beat_addr(beat_d);
                     mem_wd_data <= wline_q[beat_d*BEAT_BITS +: BEAT_BITS];
                     mem_wd_en   <= 1'b1;
                     state_q     <= WR_REQ;
                  end
               end
            end
            DONE: begin
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               req_ready  <= 1'b1;
               tmo_q      <= '0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_line_engine.sv
// tb/tb_mem_line_engine.sv - directed bench for mem_line_engine with a lagging-ack memory model
// Table of line transfers plus hand sequences for queueing, timeout and mid-transfer reset.
module tb_mem_line_engine;

   localparam int AW  = 32;
   localparam int LB  = 32;
   localparam int TMO = 64;

   logic            clk;
   logic            rst;
   logic            req_valid;
   logic            req_ready;
   logic            req_write;
   logic [AW-1:0]   req_addr;
   logic [LB*8-1:0] req_wdata;
   logic            resp_valid;
   logic [LB*8-1:0] resp_rdata;
   logic            resp_err;
   logic [AW-1:0]   mem_addr;
   logic            mem_rd_en;
   logic            mem_wd_en;
   logic [63:0]     mem_wd_data;
   logic [63:0]     mem_data;
   logic            mem_data_valid;
   logic            mem_wd_valid;

   logic            stall;
   logic [7:0]      mem [0:1023];

   int total;
   int bad;

   logic [AW-1:0] rd_addrs[$];
   logic [AW-1:0] wd_addrs[$];
   logic [63:0]   wd_datas[$];

   typedef struct {
      logic            wr;
      logic [AW-1:0]   addr;
      logic [LB*8-1:0] wdata;
      logic [LB*8-1:0] exp_rdata;
      logic [AW-1:0]   exp_a0;
      logic [63:0]     exp_d0;
   } vec_t;

   mem_line_engine #(.ADDR_W(AW), .LINE_BYTES(LB), .TIMEOUT_CYC(TMO)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_err       (resp_err),
      .mem_addr       (mem_addr),
      .mem_rd_en      (mem_rd_en),
      .mem_wd_en      (mem_wd_en),
      .mem_wd_data    (mem_wd_data),
      .mem_data       (mem_data),
      .mem_data_valid (mem_data_valid),
      .mem_wd_valid   (mem_wd_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered ack: memory answers one edge after it sees the enable, so it lags the drop too.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_data_valid <= 1'b0;
         mem_wd_valid   <= 1'b0;
         mem_data       <= '0;
         for (int i = 0; i < 1024; i++) mem[i] <= 8'(i);
      end else begin
         mem_data_valid <= mem_rd_en && !stall;
         mem_wd_valid   <= mem_wd_en && !stall;
         for (int b = 0; b < 8; b++) mem_data[8*b +: 8] <= mem[10'(mem_addr[9:0] + b)];
         if (mem_wd_en && !stall)
            for (int b = 0; b < 8; b++) mem[10'(mem_addr[9:0] + b)] <= mem_wd_data[8*b +: 8];
      end
   end

   function automatic logic [LB*8-1:0] mk_line(input logic [7:0] s);
      logic [LB*8-1:0] l;
      for (int i = 0; i < LB; i++) l[8*i +: 8] = s + 8'(i);
      return l;
   endfunction

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic monitor();
      logic prd, pwd, prv;
      logic [AW-1:0] pa;
      logic [63:0]   pd;
      prd = 1'b0; pwd = 1'b0; prv = 1'b0; pa = '0; pd = '0;
      forever begin
         @(negedge clk);
         chk("no_dual_en", mem_rd_en && mem_wd_en, 0);
         if ((mem_rd_en && prd) || (mem_wd_en && pwd)) chk("addr_stable", mem_addr, pa);
         if (mem_wd_en && pwd) chk("wdata_stable", mem_wd_data, pd);
         chk("resp_one_cycle", resp_valid && prv, 0);
         if (mem_rd_en && !prd) rd_addrs.push_back(mem_addr);
         if (mem_wd_en && !pwd) begin
            wd_addrs.push_back(mem_addr);
            wd_datas.push_back(mem_wd_data);
         end
         prd = mem_rd_en; pwd = mem_wd_en; prv = resp_valid; pa = mem_addr; pd = mem_wd_data;
      end
   endtask

   task automatic clear_logs();
      rd_addrs.delete();
      wd_addrs.delete();
      wd_datas.delete();
   endtask

   task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [LB*8-1:0] wd);
      int n;
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_wait", req_ready, 1);
      req_write = wr;
      req_addr  = a;
      req_wdata = wd;
      req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic wait_resp(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 500);
      chk("resp_seen", resp_valid, 1);
   endtask

   initial begin
      vec_t            vecs[5];
      int              n;
      int              busy_bad;
      logic [LB*8-1:0] wl;

      vecs[0] = '{1'b0, 32'h0000_0100, '0,             mk_line(8'h00), 32'h0000_0100, 64'h0};
      vecs[1] = '{1'b1, 32'h0000_0047, mk_line(8'hA0), mk_line(8'h00), 32'h0000_0040, 64'hA7A6A5A4A3A2A1A0};
      vecs[2] = '{1'b0, 32'h0000_0040, '0,             mk_line(8'hA0), 32'h0000_0040, 64'h0};
      vecs[3] = '{1'b0, 32'h0000_03FF, '0,             mk_line(8'hE0), 32'h0000_03E0, 64'h0};
      vecs[4] = '{1'b0, 32'hFFFF_FFE5, '0,             mk_line(8'hE0), 32'hFFFF_FFE0, 64'h0};

      total = 0; bad = 0;
      rst = 1'b0; stall = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;

      fork
         monitor();
      join_none

      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {req_ready, resp_valid, resp_err, mem_rd_en, mem_wd_en, mem_addr, mem_wd_data}, 0);
      chk("reset_rdata", resp_rdata, 0);
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", {req_ready, resp_valid, mem_rd_en, mem_wd_en}, 4'b1000);

      for (int i = 0; i < 5; i++) begin
         clear_logs();
         issue(vecs[i].wr, vecs[i].addr, vecs[i].wdata);
         wait_resp(n);
         chk($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
         chk($sformatf("v%0d_err", i), resp_err, 0);
         chk($sformatf("v%0d_ready_low", i), req_ready, 0);
         if (vecs[i].wr) begin
            wl = vecs[i].wdata;
            chk($sformatf("v%0d_wr_beats", i), wd_addrs.size(), 4);
            chk($sformatf("v%0d_rd_beats", i), rd_addrs.size(), 0);
            if (wd_addrs.size() == 4) begin
               chk($sformatf("v%0d_wa0", i), wd_addrs[0], vecs[i].exp_a0);
               chk($sformatf("v%0d_wa3", i), wd_addrs[3], vecs[i].exp_a0 + 32'd24);
               chk($sformatf("v%0d_wd0", i), wd_datas[0], vecs[i].exp_d0);
               chk($sformatf("v%0d_wd3", i), wd_datas[3], wl[255:192]);
            end
         end else begin
            chk($sformatf("v%0d_rd_beats", i), rd_addrs.size(), 4);
            if (rd_addrs.size() == 4) begin
               chk($sformatf("v%0d_ra0", i), rd_addrs[0], vecs[i].exp_a0);
               chk($sformatf("v%0d_ra1", i), rd_addrs[1], vecs[i].exp_a0 + 32'd8);
               chk($sformatf("v%0d_ra3", i), rd_addrs[3], vecs[i].exp_a0 + 32'd24);
            end
         end
      end

      // Two back-to-back requests with req_valid never dropping.
      clear_logs();
      n = 0;
      @(negedge clk);
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      req_write = 1'b0; req_addr = 32'h100; req_valid = 1'b1;
      @(posedge clk);
      #1 req_addr = 32'h40;
      busy_bad = 0; n = 0;
      do begin
         @(negedge clk);
         n++;
         if (req_ready) busy_bad++;
      end while (!resp_valid && n < 500);
      chk("q_busy_ready", busy_bad, 0);
      chk("q_a_resp", resp_valid, 1);
      chk("q_a_rdata", resp_rdata, mk_line(8'h00));
      @(negedge clk);
      chk("q_b_ready_after_resp", {req_ready, resp_valid}, 2'b10);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("q_b_accepted", {req_ready, mem_rd_en}, 2'b01);
      chk("q_b_addr", mem_addr, 32'h40);
      wait_resp(n);
      chk("q_b_rdata", resp_rdata, mk_line(8'hA0));

      // Memory never acks: abort exactly TMO cycles after RD_REQ entry.
      stall = 1'b1;
      issue(1'b0, 32'h200, '0);
      @(negedge clk);
      chk("to_en_at_entry", mem_rd_en, 1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 200);
      chk("to_latency", n, TMO);
      chk("to_err", {resp_valid, resp_err, mem_rd_en, mem_wd_en}, 4'b1100);
      @(negedge clk);
      chk("to_ready_after", {req_ready, resp_valid, resp_err}, 3'b100);
      stall = 1'b0;

      // Reset asserted in RD_GAP of beat 2.
      clear_logs();
      issue(1'b0, 32'h100, '0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(rd_addrs.size() == 3 && !mem_rd_en) && n < 200);
      chk("rst_reach_gap", mem_addr, 32'h110);
      rst = 1'b0;
      #1;
      chk("rst_async_outputs", {req_ready, resp_valid, resp_err, mem_rd_en, mem_wd_en, mem_addr, mem_wd_data}, 0);
      chk("rst_async_rdata", resp_rdata, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("rst_no_resp", resp_valid, 0);
      end
      rst = 1'b1;
      @(negedge clk);
      chk("rst_ready_after", {req_ready, resp_valid}, 2'b10);
      clear_logs();
      issue(1'b0, 32'h100, '0);
      wait_resp(n);
      chk("rst_fresh_rdata", resp_rdata, mk_line(8'h00));
      chk("rst_fresh_err", resp_err, 0);
      chk("rst_fresh_beats", rd_addrs.size(), 4);

      @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_line_engine.md
Name: mem_line_engine

Overview:
Initiator side of the cache-to-physical-memory interface. It accepts one line-sized request (refill or writeback) from the cache controller and issues it to the physical memory as a sequence of 64-bit little-endian beats. Each beat uses the memory's enable/valid handshake. The engine assembles refill data into a full line and returns a single-cycle response. A per-beat timeout guards against a hung memory.

Parameters:
ADDR_W, 32, byte address width
LINE_BYTES, 32, cache line size in bytes; multiple of 8; BEATS = LINE_BYTES/8
TIMEOUT_CYC, 64, maximum cycles spent in any beat state before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
req_valid  in  1  cache request present
req_ready  out  1  engine idle; request accepted when req_valid && req_ready
req_write  in  1  1 = writeback, 0 = refill
req_addr  in  ADDR_W  line address; low log2(LINE_BYTES) bits ignored
req_wdata  in  LINE_BYTES*8  writeback line; byte 0 in bits [7:0]
resp_valid  out  1  single-cycle completion pulse
resp_rdata  out  LINE_BYTES*8  refilled line; valid with resp_valid on a refill
resp_err  out  1  completion was a timeout abort; qualified by resp_valid
mem_addr  out  ADDR_W  beat byte address
mem_rd_en  out  1  beat read request
mem_wd_en  out  1  beat write request
mem_wd_data  out  64  beat write data
mem_data  in  64  read data
mem_data_valid  in  1  read beat ack/data valid
mem_wd_valid  in  1  write beat ack

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low; clk and rst are the port names.
- Reset values:
  - req_ready=1 once out of reset.
  - All other outputs are 0.
  - State=IDLE, beat counter=0, timeout counter=0.
  - Reset mid-operation abandons the transfer immediately. No response is issued for it.
- All outputs are registered.
- States: IDLE, RD_REQ, RD_GAP, WR_REQ, WR_GAP, DONE.
- IDLE:
  - req_ready=1.
  - On accept: latch base = req_addr with the low bits cleared, latch req_wdata, set beat=0, clear err.
  - Go to WR_REQ if req_write, else RD_REQ.
  - req_ready=0 in all states other than IDLE.
- RD_REQ:
  - mem_rd_en=1, mem_addr = base + 8*beat.
  - When mem_data_valid=1: capture mem_data into line[64*beat +: 64], set mem_rd_en<=0, go to RD_GAP.
- RD_GAP:
  - Hold mem_addr.
  - Because the memory samples the still-high enable at the edge where the ack is seen, valid stays high for one or more extra cycles. These trailing cycles are ignored.
  - When mem_data_valid=0: if beat==BEATS-1 go to DONE, else beat++ and go to RD_REQ.
- WR_REQ:
  - mem_wd_en=1, mem_addr = base + 8*beat, mem_wd_data = wline[64*beat +: 64].
  - When mem_wd_valid=1: set mem_wd_en<=0, go to WR_GAP.
  - The duplicate write caused by the lagging enable goes to the same address with the same data, so it is benign.
- WR_GAP:
  - Hold mem_addr and mem_wd_data.
  - When mem_wd_valid=0: last beat goes to DONE, else beat++ and go to WR_REQ.
- DONE:
  - resp_valid=1 for exactly one cycle.
  - resp_rdata is the assembled line (refill) and is held until the next refill completes.
  - resp_err = err.
  - Go to IDLE.
- Timeout:
  - Counter clears on every state entry and increments each cycle in the REQ/GAP states.
  - On reaching TIMEOUT_CYC-1: drop both enables, set err=1, go to DONE.
  - resp_rdata content is undefined on error.
- Invariants:
  - mem_rd_en and mem_wd_en are never both 1.
  - mem_addr and mem_wd_data are stable while either enable is high.
  - Enables are low in IDLE and DONE.
- Address arithmetic wraps modulo 2^ADDR_W. No carry checking is done.
- A new request is accepted no earlier than the cycle after resp_valid.

Decomposition:
- Package mem_line_pkg holds:
  - state enum typedef;
  - BEAT_BYTES=8;
  - beat-count helper function;
  - line_t typedef parameterised by width.
- No sub-module: the FSM, beat counter and timeout counter live in one module.

Test Plan:
- Refill at 0x100, memory bytes 0x100..0x11F = 0x00..0x1F:
  - four rd beats at 0x100, 0x108, 0x110, 0x118, each separated by a valid-low gap;
  - one resp_valid pulse with resp_rdata = 0x1F1E...0100 and resp_err=0.
- Writeback at req_addr 0x47 (aligned to 0x40) with wdata bytes 0xA0..0xBF:
  - four wd beats, first beat mem_wd_data = 0xA7A6A5A4A3A2A1A0;
  - a following refill of 0x40 returns the identical line.
- req_valid held high with two queued requests:
  - req_ready=0 from the accept through DONE;
  - the second request is accepted only in the cycle after resp_valid.
- Memory model never asserts mem_data_valid:
  - resp_valid with resp_err=1 exactly TIMEOUT_CYC cycles after RD_REQ entry;
  - mem_rd_en=0 afterwards and req_ready=1 the following cycle.
- rst pulsed low while in RD_GAP of beat 2:
  - all outputs 0 asynchronously and no resp_valid;
  - after release a fresh refill completes correctly.
- Concurrent assertions throughout all tests:
  - !(mem_rd_en && mem_wd_en);
  - mem_addr stable while an enable is high;
  - resp_valid never high for two consecutive cycles.
